// File: rtl/stream_demux4.sv
// rtl/stream_demux4.sv - one-deep per-lane stream demultiplexer with unicast/broadcast
// routing and saturating per-lane completed-transfer counters.
module stream_demux4 #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_sel,
  input  logic                in_bcast,
  input  logic                in_valid,
  output logic                in_ready,
  output logic [4*DATA_W-1:0] out_data,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  input  logic                cnt_clr,
  output logic [4*CNT_W-1:0]  out_cnt
);

  logic [3:0][DATA_W-1:0] data_q, data_d;
  logic [3:0]             valid_q, valid_d;
  logic [3:0][CNT_W-1:0]  cnt_q, cnt_d;

  logic [3:0] slot_free;
  logic [3:0] load;
  logic [3:0] drain;
  logic       accept;

  // A slot can take a new word if it is empty or its current word leaves this cycle.
  assign slot_free = ~valid_q | out_ready;
  assign drain     = valid_q & out_ready;

  always_comb begin
    in_ready = 1'b0;
    if (!rst) begin
      in_ready = in_bcast ? (&slot_free) : slot_free[in_sel];
    end
  end

  assign accept = in_valid & in_ready;

  always_comb begin
    load = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      load[i] = accept & (in_bcast | (in_sel == 2'(i)));
    end
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < 4; i++) begin
      if (load[i]) begin
        data_d[i]  = in_data;
        valid_d[i] = 1'b1;
      end else if (drain[i]) begin
        valid_d[i] = 1'b0;
      end
      // Clear wins over a coincident transfer; the count sticks at all-ones.
      if (cnt_clr) begin
        cnt_d[i] = '0;
      end else if (drain[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 4'b0000;
      cnt_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_stream_demux4.sv
// tb/tb_stream_demux4.sv - scoreboard bench for stream_demux4: per-lane expected-word queues
// filled at acceptance and drained by a handshake monitor.
module tb_stream_demux4;

  localparam int DW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] in_data;
  logic [1:0]    in_sel;
  logic          in_bcast;
  logic          in_valid;
  logic          in_ready;
  logic [4*DW-1:0] out_data;
  logic [3:0]    out_valid;
  logic [3:0]    out_ready;
  logic          cnt_clr;
  logic [4*CW-1:0] out_cnt;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] exp_q [4][$];
  logic [DW-1:0] mon_exp;

  always #5 clk = ~clk;

  stream_demux4 #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .in_bcast  (in_bcast),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt_clr   (cnt_clr),
    .out_cnt   (out_cnt)
  );

  // Every completed lane handshake must deliver the oldest outstanding word for that lane.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        if (out_valid[i] && out_ready[i]) begin
          total++;
          if (exp_q[i].size() == 0) begin
            bad++;
            $display("FAIL lane%0d_unexpected_word got=%h required=none", i, out_data[i*DW +: DW]);
          end else begin
            mon_exp = exp_q[i].pop_front();
            if (out_data[i*DW +: DW] !== mon_exp) begin
              bad++;
              $display("FAIL lane%0d_data got=%h required=%h", i, out_data[i*DW +: DW], mon_exp);
            end
          end
        end
      end
    end
  end

  task automatic clear_queues();
    for (int i = 0; i < 4; i++) exp_q[i].delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b0; in_bcast = 1'b0; cnt_clr = 1'b0;
    clear_queues();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic send(input logic [DW-1:0] d, input logic [1:0] s, input logic b);
    int n;
    n = 0;
    in_data = d; in_sel = s; in_bcast = b; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL send_timeout got=in_ready=0 required=in_ready=1 data=%h", d);
    end else if (b) begin
      for (int i = 0; i < 4; i++) exp_q[i].push_back(d);
    end else begin
      exp_q[s].push_back(d);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_bcast = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b required=0000", out_valid); end
    total++;
    if (out_data !== '0) begin bad++; $display("FAIL reset_data got=%h required=0", out_data); end
    total++;
    if (out_cnt !== '0) begin bad++; $display("FAIL reset_cnt got=%h required=0", out_cnt); end
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b required=0", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL post_reset_in_ready got=%b required=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_unicast();
    do_reset();
    out_ready = 4'b1111;
    send(8'hA5, 2'd2, 1'b0);
    total++;
    if (out_valid !== 4'b0100) begin bad++; $display("FAIL unicast_valid got=%b required=0100", out_valid); end
    total++;
    if (out_data[2*DW +: DW] !== 8'hA5) begin bad++; $display("FAIL unicast_lane2 got=%h required=a5", out_data[2*DW +: DW]); end
    @(posedge clk);
    #1;
    total++;
    if (out_valid !== 4'b0000) begin bad++; $display("FAIL unicast_one_cycle got=%b required=0000", out_valid); end
    total++;
    if (out_cnt !== 64'h0000_0001_0000_0000) begin bad++; $display("FAIL unicast_cnt got=%h required=0000000100000000", out_cnt); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 4'b1101;
    send(8'h11, 2'd1, 1'b0);
    in_data = 8'h22; in_sel = 2'd1; in_bcast = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready_low got=%b required=0", in_ready); end
      total++;
      if (out_valid[1] !== 1'b1 || out_data[DW +: DW] !== 8'h11) begin
        bad++; $display("FAIL bp_hold got=%b/%h required=1/11", out_valid[1], out_data[DW +: DW]);
      end
      @(posedge clk);
      #1;
    end
    out_ready = 4'b1111;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_in_ready_high got=%b required=1", in_ready); end
    exp_q[1].push_back(8'h22);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_cnt[CW +: CW] !== 16'd2) begin bad++; $display("FAIL bp_cnt got=%0d required=2", out_cnt[CW +: CW]); end
  endtask

  task automatic test_broadcast();
    do_reset();
    out_ready = 4'b0111;
    send(8'h33, 2'd3, 1'b0);
    in_data = 8'h44; in_sel = 2'd0; in_bcast = 1'b1; in_valid = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      total++;
      if (in_ready !== 1'b0) begin bad++; $display("FAIL bcast_blocked got=%b required=0", in_ready); end
      @(posedge clk);
      #1;
    end
    out_ready = 4'b1111;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bcast_ready got=%b required=1", in_ready); end
    for (int i = 0; i < 4; i++) exp_q[i].push_back(8'h44);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_bcast = 1'b0;
    total++;
    if (out_valid !== 4'b1111 || out_data !== 32'h44444444) begin
      bad++; $display("FAIL bcast_all_lanes got=%b/%h required=1111/44444444", out_valid, out_data);
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_streaming();
    do_reset();
    out_ready = 4'b1111;
    for (int k = 1; k <= 8; k++) begin
      in_data = 8'(k); in_sel = 2'd0; in_bcast = 1'b0; in_valid = 1'b1;
      @(negedge clk);
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready word=%0d got=%b required=1", k, in_ready); end
      exp_q[0].push_back(8'(k));
      if (k >= 2) begin
        total++;
        if (out_valid[0] !== 1'b1) begin bad++; $display("FAIL stream_valid word=%0d got=%b required=1", k, out_valid[0]); end
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    total++;
    if (out_valid[0] !== 1'b1) begin bad++; $display("FAIL stream_last_valid got=%b required=1", out_valid[0]); end
    @(posedge clk);
    #1;
    @(negedge clk);
    total++;
    if (out_valid[0] !== 1'b0) begin bad++; $display("FAIL stream_end_valid got=%b required=0", out_valid[0]); end
    total++;
    if (out_cnt[CW-1:0] !== 16'd8) begin bad++; $display("FAIL stream_cnt got=%0d required=8", out_cnt[CW-1:0]); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_counter();
    int drops;
    drops = 0;
    do_reset();
    out_ready = 4'b1111;
    in_sel = 2'd0; in_bcast = 1'b0; in_valid = 1'b1;
    for (int k = 0; k < (1 << CW) + 3; k++) begin
      in_data = 8'(k);
      @(negedge clk);
      if (in_ready) exp_q[0].push_back(8'(k));
      else drops++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    total++;
    if (drops != 0) begin bad++; $display("FAIL counter_stream_stalls got=%0d required=0", drops); end
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (out_cnt[CW-1:0] !== 16'hFFFF) begin bad++; $display("FAIL counter_saturate got=%h required=ffff", out_cnt[CW-1:0]); end
    send(8'h5A, 2'd0, 1'b0);
    cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    cnt_clr = 1'b0;
    total++;
    if (out_cnt[CW-1:0] !== 16'h0000) begin bad++; $display("FAIL counter_clear_priority got=%h required=0000", out_cnt[CW-1:0]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    out_ready = 4'b1111;
    send(8'h77, 2'd1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    out_ready = 4'b0000;
    send(8'h55, 2'd0, 1'b0);
    send(8'h66, 2'd2, 1'b0);
    total++;
    if (out_valid !== 4'b0101) begin bad++; $display("FAIL mid_fill got=%b required=0101", out_valid); end
    rst = 1'b1;
    clear_queues();
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin bad++; $display("FAIL mid_rst_in_ready got=%b required=0", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    total++;
    if (out_valid !== 4'b0000 || out_cnt !== '0 || out_data !== '0) begin
      bad++; $display("FAIL mid_rst_state got=%b/%h/%h required=0000/0/0", out_valid, out_cnt, out_data);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL mid_rst_release got=%b required=1", in_ready); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    int left;
    rst = 1'b1; in_data = '0; in_sel = 2'd0; in_bcast = 1'b0; in_valid = 1'b0;
    out_ready = 4'b0000; cnt_clr = 1'b0;
    test_reset();
    test_unicast();
    test_backpressure();
    test_broadcast();
    test_streaming();
    test_reset_mid();
    test_counter();
    repeat (3) @(posedge clk);
    #1;
    left = 0;
    for (int i = 0; i < 4; i++) left += exp_q[i].size();
    total++;
    if (left != 0) begin bad++; $display("FAIL undelivered_words got=%0d required=0", left); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
